vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; HS_POL 0 and VS_POL 0, the sync active level; CLK_DIV 2 CLOCK_50 cycles per pixel (even, >=2); COLOR_W 8 bits per channel.
REQ-002 CLOCK_50 input 1: sole clock, every flop on its rising edge.
REQ-003 reset input 1: asynchronous, active-low reset.
REQ-004 VGA_R_in/VGA_G_in/VGA_B_in input COLOR_W each: colour of pixel (j,i), sampled on pix_en.
REQ-005 pattern_sel input 1: selects internal test pattern (REQ-022).
REQ-006 VGA_CLK output 1: registered pixel clock, period CLK_DIV CLOCK_50 cycles.
REQ-007 VGA_SYNC_N output 1 tied 0; VGA_BLANK_N output 1 registered, high during visible pixels.
REQ-008 VGA_R/VGA_G/VGA_B output COLOR_W each; VGA_HS, VGA_VS output 1.
REQ-009 j output 12 (column), i output 12 (line), printing output 1: current counter position and its visibility, unregistered.
REQ-010 line_start, frame_start output 1: one-CLOCK_50-cycle pulses.

Function
REQ-011 Internal div counter 0..CLK_DIV-1; pix_en=1 for the cycle div==CLK_DIV-1.
REQ-012 VGA_CLK SHALL be 0 for div 0..CLK_DIV/2-1 and 1 otherwise, registered (rises mid-pixel).
REQ-013 h_cnt advances on pix_en over 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; wraps to 0 and advances v_cnt over 0..V_TOTAL-1 (V_TOTAL likewise), both wrapping to 0 together at (H_TOTAL-1,V_TOTAL-1).
REQ-014 Region order per line: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; same order vertically.
REQ-015 j=h_cnt, i=v_cnt; printing=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
REQ-016 On pix_en, outputs register from current counters: VGA_HS=HS_POL inside h sync else ~HS_POL; VGA_VS likewise; VGA_BLANK_N=printing; RGB=selected colour if printing else 0.
REQ-017 Latency: all VGA_* pixel outputs lag (j,i,printing) by exactly one pixel; sync and colour mutually aligned.
REQ-018 line_start pulses on the pix_en cycle where h_cnt==0; frame_start where h_cnt==0 and v_cnt==0.
REQ-019 Outputs hold between pix_en cycles.
REQ-020 Parameter violation (CLK_DIV odd or <2, any timing field 0) is unsupported; bench does not test it.

Reset
REQ-021 reset low asynchronously clears div, h_cnt, v_cnt, VGA_CLK, RGB, VGA_BLANK_N, line_start, frame_start to 0, and sets VGA_HS=~HS_POL, VGA_VS=~VS_POL; release mid-frame restarts at (0,0), first pix_en CLK_DIV cycles later.

Configuration
REQ-022 Macro VGA_TEST_PATTERN_EN defined: when pattern_sel=1, colour is 8 vertical bars, bar k=j*8/H_ACTIVE, R=all-ones if k[2], G if k[1], B if k[0], else 0; VGA_*_in ignored. Undefined: pattern_sel ignored, VGA_*_in always used, no pattern logic.

Verification
REQ-023 Defaults, 1e6 cycles -> VGA_CLK period 2 cycles; line 800 pixels = 1600 cycles; frame 525 lines = 840000 cycles; frame_start every 840000 cycles.
REQ-024 Defaults -> VGA_HS low for 96 pixels starting one pixel after h_cnt=656; VGA_VS low for lines 490-491 (plus one-pixel lag); VGA_BLANK_N high exactly 640x480 pixels/frame.
REQ-025 VGA_R_in=j[7:0] -> VGA_R equals j of the previous pixel while VGA_BLANK_N=1, 0 when blanked.
REQ-026 reset low at h_cnt=300,v_cnt=200 for 3 cycles -> immediate reset values; after release j=0,i=0, frame_start on first pix_en.
REQ-027 CLK_DIV=4, H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24, V_ACTIVE=240 -> line 400 pixels=1600 cycles, VGA_CLK high cycles 2-3 of each pixel.
REQ-028 VGA_TEST_PATTERN_EN defined, pattern_sel=1 -> pixels 0-79 black, 80-159 blue, 560-639 white; undefined -> VGA_*_in passed through regardless of pattern_sel.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//
// Purpose : Bundles the pixel-side signals of the VGA timing generator so that
//           the generator and its consumer/driver share one port. The clock
//           and reset stay outside the bundle.
//
// Signals :
//   VGA_R_in/VGA_G_in/VGA_B_in [COLOR_W] - colour of the current pixel (j,i)
//   pattern_sel                          - request the built-in colour bars
//   VGA_CLK                              - pixel clock
//   VGA_SYNC_N                           - composite sync, always 0
//   VGA_BLANK_N                          - high while a visible pixel is shown
//   VGA_R/VGA_G/VGA_B [COLOR_W]          - registered colour
//   VGA_HS/VGA_VS                        - registered sync pulses
//   j/i [12]                             - current column / line counters
//   printing                             - current position is visible
//   line_start/frame_start               - one-cycle position markers
//
// Modports:
//   master - the timing generator (drives the VGA_* outputs and counters)
//   slave  - whoever supplies colour and consumes the timing
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
   parameter int COLOR_W = 8
);
   logic [COLOR_W-1:0] VGA_R_in;
   logic [COLOR_W-1:0] VGA_G_in;
   logic [COLOR_W-1:0] VGA_B_in;
   logic               pattern_sel;

   logic               VGA_CLK;
   logic               VGA_SYNC_N;
   logic               VGA_BLANK_N;
   logic [COLOR_W-1:0] VGA_R;
   logic [COLOR_W-1:0] VGA_G;
   logic [COLOR_W-1:0] VGA_B;
   logic               VGA_HS;
   logic               VGA_VS;
   logic [11:0]        j;
   logic [11:0]        i;
   logic               printing;
   logic               line_start;
   logic               frame_start;

   modport master (
      input  VGA_R_in, VGA_G_in, VGA_B_in, pattern_sel,
      output VGA_CLK, VGA_SYNC_N, VGA_BLANK_N,
      output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
      output j, i, printing, line_start, frame_start
   );

   modport slave (
      output VGA_R_in, VGA_G_in, VGA_B_in, pattern_sel,
      input  VGA_CLK, VGA_SYNC_N, VGA_BLANK_N,
      input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
      input  j, i, printing, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose : VGA raster timing generator. CLOCK_50 is divided by CLK_DIV into a
//           pixel enable; a column counter (j) and line counter (i) walk the
//           full raster (active, front porch, sync, back porch in that order,
//           both axes). On each pixel enable the sync, blank and colour outputs
//           are registered from the current counter position, so every VGA_*
//           pixel output lags (j,i,printing) by exactly one pixel.
//
// Ports   :
//   CLOCK_50 in  - sole clock, all flops on its rising edge
//   reset    in  - asynchronous, active-low reset
//   vga      master modport of vga_timing_gen_if:
//      in : VGA_R_in/VGA_G_in/VGA_B_in, pattern_sel
//      out: VGA_CLK, VGA_SYNC_N (tied 0), VGA_BLANK_N, VGA_R/G/B,
//           VGA_HS, VGA_VS, j, i, printing, line_start, frame_start
//
// Build option:
//   VGA_TEST_PATTERN_EN - when defined, pattern_sel=1 replaces the incoming
//                         colour with eight vertical colour bars. When not
//                         defined, pattern_sel is ignored and no bar logic
//                         exists.
//
// Parameter notes: CLK_DIV must be even and >= 2, and no timing field may be
// zero; other values are not supported.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2,
   parameter int COLOR_W  = 8
) (
   input logic              CLOCK_50,
   input logic              reset,
   vga_timing_gen_if.master vga
);

   // --------------------------------------------------------------------------
   // Derived constants
   // --------------------------------------------------------------------------
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
   localparam logic [11:0] H_SS_C    = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SE_C    = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST_C  = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
   localparam logic [11:0] V_SS_C    = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SE_C    = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST_C  = 12'(V_TOTAL - 1);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [DIV_W-1:0]   r_div;
   logic               r_vga_clk;
   logic [11:0]        r_h_cnt;
   logic [11:0]        r_v_cnt;
   logic               r_hs;
   logic               r_vs;
   logic               r_blank_n;
   logic [COLOR_W-1:0] r_r;
   logic [COLOR_W-1:0] r_g;
   logic [COLOR_W-1:0] r_b;
   logic               r_line_start;
   logic               r_frame_start;

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   logic               w_pix_en;
   logic [DIV_W-1:0]   w_div_next;
   logic               w_h_last;
   logic               w_v_last;
   logic               w_printing;
   logic               w_h_sync;
   logic               w_v_sync;
   logic [COLOR_W-1:0] w_sel_r;
   logic [COLOR_W-1:0] w_sel_g;
   logic [COLOR_W-1:0] w_sel_b;

   assign w_pix_en   = (r_div == DIV_LAST);
   assign w_div_next = w_pix_en ? '0 : (r_div + 1'b1);
   assign w_h_last   = (r_h_cnt == H_LAST_C);
   assign w_v_last   = (r_v_cnt == V_LAST_C);
   assign w_printing = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
   assign w_h_sync   = (r_h_cnt >= H_SS_C) && (r_h_cnt < H_SE_C);
   assign w_v_sync   = (r_v_cnt >= V_SS_C) && (r_v_cnt < V_SE_C);

   // --------------------------------------------------------------------------
   // Colour source selection
   // --------------------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
   // Bar index k = j*8/H_ACTIVE is formed without a divider: k is the number
   // of bar boundaries the column has reached, where boundary m sits at
   // ceil(m*H_ACTIVE/8).
   logic [6:0] w_bar_ge;
   logic [2:0] w_bar;

   for (genvar gi = 1; gi < 8; gi++) begin : g_bar_th
      localparam logic [11:0] BAR_TH = 12'((gi * H_ACTIVE + 7) / 8);
      assign w_bar_ge[gi-1] = (r_h_cnt >= BAR_TH);
   end

   always_comb begin
      w_bar = '0;
      for (int k = 0; k < 7; k++) begin
         w_bar = w_bar + {2'b00, w_bar_ge[k]};
      end
   end

   always_comb begin
      w_sel_r = vga.VGA_R_in;
      w_sel_g = vga.VGA_G_in;
      w_sel_b = vga.VGA_B_in;
      if (vga.pattern_sel) begin
         w_sel_r = {COLOR_W{w_bar[2]}};
         w_sel_g = {COLOR_W{w_bar[1]}};
         w_sel_b = {COLOR_W{w_bar[0]}};
      end
   end
`else
   // Without the pattern generator the select input has no function.
   logic w_unused_pattern_sel;
   assign w_unused_pattern_sel = vga.pattern_sel;

   assign w_sel_r = vga.VGA_R_in;
   assign w_sel_g = vga.VGA_G_in;
   assign w_sel_b = vga.VGA_B_in;
`endif

   // --------------------------------------------------------------------------
   // Pixel divider, pixel clock and raster counters
   // --------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_div     <= '0;
         r_vga_clk <= 1'b0;
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
      end else begin
         r_div     <= w_div_next;
         // Registered from the next divider value so VGA_CLK lines up with
         // r_div: low for the first half of each pixel, high for the second.
         r_vga_clk <= (w_div_next >= DIV_HALF);
         if (w_pix_en) begin
            if (w_h_last) begin
               r_h_cnt <= '0;
               r_v_cnt <= w_v_last ? '0 : (r_v_cnt + 12'd1);
            end else begin
               r_h_cnt <= r_h_cnt + 12'd1;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Position markers
   // --------------------------------------------------------------------------
   // The markers must be high during the pixel-enable cycle itself, yet come
   // from flops. They are loaded one cycle early (divider at CLK_DIV-2); the
   // counters cannot change on that edge because it is never a pixel-enable
   // edge, so the values tested here are the ones present during pix_en.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= (r_div == DIV_PRE) && (r_h_cnt == '0);
         r_frame_start <= (r_div == DIV_PRE) && (r_h_cnt == '0) && (r_v_cnt == '0);
      end
   end

   // --------------------------------------------------------------------------
   // Pixel outputs: sampled from the current position on each pixel enable,
   // held in between. This is where the one-pixel lag comes from.
   // --------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_hs      <= ~HS_POL;
         r_vs      <= ~VS_POL;
         r_blank_n <= 1'b0;
         r_r       <= '0;
         r_g       <= '0;
         r_b       <= '0;
      end else if (w_pix_en) begin
         r_hs      <= w_h_sync ? HS_POL : ~HS_POL;
         r_vs      <= w_v_sync ? VS_POL : ~VS_POL;
         r_blank_n <= w_printing;
         r_r       <= w_printing ? w_sel_r : '0;
         r_g       <= w_printing ? w_sel_g : '0;
         r_b       <= w_printing ? w_sel_b : '0;
      end
   end

   // --------------------------------------------------------------------------
   // Output mapping
   // --------------------------------------------------------------------------
   assign vga.VGA_CLK     = r_vga_clk;
   assign vga.VGA_SYNC_N  = 1'b0;
   assign vga.VGA_BLANK_N = r_blank_n;
   assign vga.VGA_R       = r_r;
   assign vga.VGA_G       = r_g;
   assign vga.VGA_B       = r_b;
   assign vga.VGA_HS      = r_hs;
   assign vga.VGA_VS      = r_vs;
   assign vga.j           = r_h_cnt;
   assign vga.i           = r_v_cnt;
   assign vga.printing    = w_printing;
   assign vga.line_start  = r_line_start;
   assign vga.frame_start = r_frame_start;

endmodule
